alarm_tone_gen: RTL

Parametrised multi-mode alarm sounder driving a single square-wave speaker pin. It supports four selectable patterns: steady, two-tone alternating, sweeping wail, and pulsed beep. All tone and timing constants are parameters, so the block runs at any system clock and simulates quickly with small values. It sits behind the alarm controller, which drives `enable` and `mode`.

---
 rtl/alarm_tone_gen.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alarm_tone_gen.sv
// alarm_tone_gen: multi-mode alarm sounder driving one square-wave speaker pin.
// Supports four patterns: steady tone, two-tone alternation, sweeping wail and
// pulsed beep. A single tone engine counts half-periods of the current divider.
// A phase timer and a sweep-step timer change that divider, or gate the tone.
module alarm_tone_gen #(
    parameter int unsigned LO_DIV       = 56818,
    parameter int unsigned HI_DIV       = 28409,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned PHASE_CYCLES = 25_000_000,
    parameter int unsigned STEP_CYCLES  = 50_000,
    parameter int unsigned SWEEP_STEP   = 284
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] mode,
    output logic       speaker_out,
    output logic       active,
    output logic       tone_sel
);

    typedef enum logic [1:0] {
        STEADY   = 2'd0,
        TWO_TONE = 2'd1,
        WAIL     = 2'd2,
        BEEP     = 2'd3
    } mode_t;

    localparam int unsigned PH_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int unsigned ST_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [DIV_W-1:0] LO_D    = DIV_W'(LO_DIV);
    localparam logic [DIV_W-1:0] HI_D    = DIV_W'(HI_DIV);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PHASE_CYCLES - 1);
    localparam logic [ST_W-1:0]  ST_LAST = ST_W'(STEP_CYCLES - 1);

    // Sweep arithmetic carries one extra bit so a step never wraps before clamping.
    localparam logic [DIV_W:0] LO_X   = (DIV_W + 1)'(LO_DIV);
    localparam logic [DIV_W:0] HI_X   = (DIV_W + 1)'(HI_DIV);
    localparam logic [DIV_W:0] STEP_X = (DIV_W + 1)'(SWEEP_STEP);

    // All pattern state that returns to a common clear value on disable/restart.
    typedef struct packed {
        logic [DIV_W-1:0] tone_cnt;
        logic [DIV_W-1:0] cur_div;
        logic [PH_W-1:0]  phase_cnt;
        logic [ST_W-1:0]  step_cnt;
        logic             tone_sel;
        logic             gate;
        logic             spk;
    } state_t;

    localparam state_t CLEAR_ST = '{
        tone_cnt:  '0,
        cur_div:   LO_D,
        phase_cnt: '0,
        step_cnt:  '0,
        tone_sel:  1'b0,
        gate:      1'b1,
        spk:       1'b0
    };

    state_t st;
    mode_t  mode_q;
    mode_t  mode_in;
    logic   en_q;

    logic             phase_tick;
    logic             step_tick;
    logic             tone_wrap;
    logic             gate_next;
    logic [DIV_W:0]   div_x;
    logic [DIV_W:0]   div_dn;
    logic [DIV_W:0]   div_up;

    assign mode_in = mode_t'(mode);

    // Timer ticks, tone wrap condition, next beep gate and clamped sweep targets.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        phase_tick = 1'b0;
        step_tick  = 1'b0;
        tone_wrap  = 1'b0;
        gate_next  = st.gate;
        div_x      = {1'b0, st.cur_div};
        div_dn     = HI_X;
        div_up     = LO_X;

        phase_tick = (st.phase_cnt == PH_LAST);
        step_tick  = (st.step_cnt == ST_LAST);
        // >= rather than == so a divider that shrank below the count wraps at once.
        tone_wrap  = (st.tone_cnt >= (st.cur_div - DIV_W'(1)));

        if ((mode_q == BEEP) && phase_tick) begin
            gate_next = ~st.gate;
        end

        if (div_x > (HI_X + STEP_X)) begin
            div_dn = div_x - STEP_X;
        end
        if ((div_x + STEP_X) < LO_X) begin
            div_up = div_x + STEP_X;
        end
    end

    // Pattern state machine: reset, disable, restart on mode change, then run.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is written only with non-blocking assignments.
        if (rst) begin
            st     <= CLEAR_ST;
            mode_q <= STEADY;
            en_q   <= 1'b0;
        end else if (!enable) begin
            st     <= CLEAR_ST;
            mode_q <= mode_in;
            en_q   <= 1'b0;
        end else if (mode_in != mode_q) begin
            st     <= CLEAR_ST;
            mode_q <= mode_in;
            en_q   <= 1'b1;
        end else begin
            en_q         <= 1'b1;
            st.phase_cnt <= phase_tick ? '0 : st.phase_cnt + PH_W'(1);
            st.step_cnt  <= step_tick ? '0 : st.step_cnt + ST_W'(1);
            st.gate      <= gate_next;

            // Tone runs only while the gate is open now and stays open this edge.
            if (st.gate && gate_next) begin
                if (tone_wrap) begin
                    st.tone_cnt <= '0;
                    st.spk      <= ~st.spk;
                end else begin
                    st.tone_cnt <= st.tone_cnt + DIV_W'(1);
                end
            end else begin
                st.tone_cnt <= '0;
                st.spk      <= 1'b0;
            end

            case (mode_q)
                STEADY: begin
                    st.cur_div  <= LO_D;
                    st.tone_sel <= 1'b0;
                end
                TWO_TONE: begin
                    if (phase_tick) begin
                        st.tone_sel <= ~st.tone_sel;
                        st.cur_div  <= st.tone_sel ? LO_D : HI_D;
                    end
                end
                WAIL: begin
                    if (step_tick) begin
                        if (!st.tone_sel) begin
                            st.cur_div <= div_dn[DIV_W-1:0];
                            if (div_dn == HI_X) begin
                                st.tone_sel <= 1'b1;
                            end
                        end else begin
                            st.cur_div <= div_up[DIV_W-1:0];
                            if (div_up == LO_X) begin
                                st.tone_sel <= 1'b0;
                            end
                        end
                    end
                end
                BEEP: begin
                    st.cur_div  <= LO_D;
                    st.tone_sel <= 1'b0;
                end
            endcase
        end
    end

    assign speaker_out = st.spk;
    assign tone_sel    = st.tone_sel;
    assign active      = en_q & st.gate;

endmodule
